// File: rtl/mmcam_pkg.sv
// Shared definitions for the matching-memory CAM controller.
// Holds the FSM state encoding, operation kinds and default geometry.
package mmcam_pkg;

    localparam int DEF_ENTRIES = 64;
    localparam int DEF_ADDR_W  = 6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_STALL = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE   = 2'd0,
        OP_WRITE  = 2'd1,
        OP_DELETE = 2'd2,
        OP_BYPASS = 2'd3
    } op_kind_t;

endpackage

// File: rtl/mmcam_prio_enc.sv
// Rotating priority encoder: finds the first set bit of vec scanning
// upward from index start and wrapping around. WIDTH must be 2**IDX_W,
// so the wrap is a plain truncation of the index arithmetic.
module mmcam_prio_enc
    import mmcam_pkg::*;
#(
    parameter int WIDTH = DEF_ENTRIES,
    parameter int IDX_W = DEF_ADDR_W
) (
    input  logic [WIDTH-1:0] vec,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    logic [IDX_W-1:0] cand;

    // Scan from the far end back toward start so the last hit kept is the nearest one.
    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = '0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            cand = start + IDX_W'(k);
            if (vec[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/mmcam_ctrl.sv
// Matching-memory CAM controller: classifies each offered packet as a
// bypass, a delete of the matching entry or a write into a free entry,
// stalling while the memory is full. Tracks occupancy and a sticky error.
// Optional feature: define MMCAM_CTRL_RR_ALLOC_EN to make the free-entry
// search start after the last written index instead of at index 0.
module mmcam_ctrl
    import mmcam_pkg::*;
#(
    parameter int ENTRIES = DEF_ENTRIES,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic               CP,
    input  logic               MR_N,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic               MF,
    input  logic [ENTRIES-1:0] FIRE,
    input  logic [ENTRIES-1:0] VALID,
    output logic [ENTRIES-1:0] EN,
    output logic               WR_E,
    output logic               DEL,
    output logic               BYP,
    output logic               OP_VALID,
    output logic [ADDR_W-1:0]  ADDR,
    output logic [ADDR_W:0]    OCC,
    output logic               FULL,
    output logic               ERR
);

    localparam logic [ADDR_W:0]    OCC_MAX = (ADDR_W + 1)'(ENTRIES);
    localparam logic [ENTRIES-1:0] ONE     = {{(ENTRIES - 1){1'b0}}, 1'b1};

    state_t              state;
    op_kind_t            op_sel;
    logic                take;
    logic                fire_found;
    logic [ADDR_W-1:0]   fire_idx;
    logic                fire_multi;
    logic                free_found;
    logic [ADDR_W-1:0]   free_idx;
    logic [ADDR_W-1:0]   alloc_start;
    logic [ENTRIES-1:0]  one_hot;

    mmcam_prio_enc #(
        .WIDTH (ENTRIES),
        .IDX_W (ADDR_W)
    ) u_fire_enc (
        .vec   (FIRE),
        .start ('0),
        .found (fire_found),
        .index (fire_idx)
    );

    mmcam_prio_enc #(
        .WIDTH (ENTRIES),
        .IDX_W (ADDR_W)
    ) u_free_enc (
        .vec   (~VALID),
        .start (alloc_start),
        .found (free_found),
        .index (free_idx)
    );

    assign fire_multi = |(FIRE & (FIRE - ONE));
    assign one_hot    = ONE << free_idx;
    assign IN_READY   = (state == S_IDLE);
    assign FULL       = (OCC == OCC_MAX);
    assign take       = ((state == S_IDLE) && IN_VALID) || (state == S_STALL);

`ifdef MMCAM_CTRL_RR_ALLOC_EN
    logic [ADDR_W-1:0] alloc_ptr;

    // Remember the slot after the last write so allocation rotates through the memory.
    always_ff @(posedge CP or negedge MR_N) begin
        if (!MR_N) begin
            alloc_ptr <= '0;
        end else if (take && (op_sel == OP_WRITE)) begin
            alloc_ptr <= free_idx + ADDR_W'(1);
        end
    end

    assign alloc_start = alloc_ptr;
`else
    assign alloc_start = '0;
`endif

    // Classify the packet; a stalled packet always needs matching, so MF is only consulted in IDLE.
    always_comb begin
        op_sel = OP_NONE;
        if ((state == S_IDLE) && !MF) begin
            op_sel = OP_BYPASS;
        end else if (fire_found) begin
            op_sel = OP_DELETE;
        end else if (free_found) begin
            op_sel = OP_WRITE;
        end
    end

    // Controller FSM with registered operation pulses, address, occupancy and error.
    always_ff @(posedge CP or negedge MR_N) begin
        if (!MR_N) begin
            state    <= S_IDLE;
            ADDR     <= '0;
            EN       <= '0;
            WR_E     <= 1'b0;
            DEL      <= 1'b0;
            BYP      <= 1'b0;
            OP_VALID <= 1'b0;
            OCC      <= '0;
            ERR      <= 1'b0;
        end else begin
            EN       <= '0;
            WR_E     <= 1'b0;
            DEL      <= 1'b0;
            BYP      <= 1'b0;
            OP_VALID <= 1'b0;
            case (state)
                S_IDLE, S_STALL: begin
                    if (take) begin
                        case (op_sel)
                            OP_BYPASS: begin
                                BYP      <= 1'b1;
                                OP_VALID <= 1'b1;
                                state    <= S_ISSUE;
                            end
                            OP_DELETE: begin
                                DEL      <= 1'b1;
                                OP_VALID <= 1'b1;
                                ADDR     <= fire_idx;
                                state    <= S_ISSUE;
                                if (fire_multi || (OCC == '0)) begin
                                    ERR <= 1'b1;
                                end
                                if (OCC != '0) begin
                                    OCC <= OCC - 1'b1;
                                end
                            end
                            OP_WRITE: begin
                                WR_E     <= 1'b1;
                                OP_VALID <= 1'b1;
                                EN       <= one_hot;
                                ADDR     <= free_idx;
                                state    <= S_ISSUE;
                                if (OCC == OCC_MAX) begin
                                    ERR <= 1'b1;
                                end else begin
                                    OCC <= OCC + 1'b1;
                                end
                            end
                            default: begin
                                state <= S_STALL;
                            end
                        endcase
                    end
                end
                S_ISSUE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
